// File: rtl/transmit_counter_pkg.sv
// -----------------------------------------------------------------------------
// transmit_counter_pkg
//   Shared definitions for the multi-channel transmit counter:
//     - tx_state_e   : firing FSM state encoding (IDLE, RUN, GAP, DONE)
//     - params_valid : elaboration-time check that the pulse shape fits inside
//                      the time range reachable with COUNT_W-bit delays
// -----------------------------------------------------------------------------
package transmit_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } tx_state_e;

    // The global time counter is COUNT_W+1 bits wide; the largest window end
    // (2**COUNT_W - 1 + PULSE_LEN) must stay representable in it.
    function automatic bit params_valid(input int pulse_len, input int count_w);
        return (pulse_len >= 1) && (count_w >= 1) && (count_w <= 30) &&
               (longint'(pulse_len) <= (longint'(1) << count_w));
    endfunction

endpackage

// File: rtl/tx_channel.sv
// -----------------------------------------------------------------------------
// tx_channel
//   One transmit channel. Compares the global time against this channel's
//   delay window [delay, delay + PULSE_LEN) and drives the matching shape bit
//   onto a registered output. Outside the window, or when not enabled, the
//   output is driven low on the next edge.
//
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-low reset
//   t       in   [COUNT_W:0]     global time within the current repetition
//   delay   in   [COUNT_W-1:0]   start delay of this channel
//   enable  in   channel enabled and firing active this cycle
//   shape   in   [PULSE_LEN-1:0] pulse shape, bit j sent at window offset j
//   pulse   out  registered transducer drive
// -----------------------------------------------------------------------------
module tx_channel #(
    parameter int COUNT_W   = 16,
    parameter int PULSE_LEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COUNT_W:0]     t,
    input  logic [COUNT_W-1:0]   delay,
    input  logic                 enable,
    input  logic [PULSE_LEN-1:0] shape,
    output logic                 pulse
);

    localparam int CW1 = COUNT_W + 1;
    localparam logic [COUNT_W:0] LEN_EXT = CW1'(PULSE_LEN);

    logic [COUNT_W:0] d_ext;
    logic [COUNT_W:0] offset;
    logic             in_window;
    logic             shape_bit;

    // Unsigned compare at COUNT_W+1 bits: d_ext + LEN_EXT cannot overflow.
    assign d_ext     = {1'b0, delay};
    assign offset    = t - d_ext;
    assign in_window = (t >= d_ext) && (t < d_ext + LEN_EXT);

    always_comb begin
        // NOTE: default before the loop so no path leaves shape_bit unassigned (no latch).
        shape_bit = 1'b0;
        for (int j = 0; j < PULSE_LEN; j++) begin
            if (offset == CW1'(j)) shape_bit = shape[j];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking for all flop updates so every flop samples pre-edge values.
            pulse <= enable & in_window & shape_bit;
        end
    end

endmodule

// File: rtl/multi_channel_transmit_counter.sv
// -----------------------------------------------------------------------------
// multi_channel_transmit_counter
//   Fires one stored pulse shape on NUM_CH transmit channels, each offset by
//   its own delay, optionally repeated as a burst with a programmable gap.
//   Holds the shadow configuration, the firing FSM, the repetition and gap
//   counters and the per-repetition end time T_end.
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-low reset
//   load         in   latch configuration (IDLE/DONE only, wins over start)
//   delay_in     in   [NUM_CH*COUNT_W-1:0] channel i delay at [i*COUNT_W +: COUNT_W]
//   pulse_shape  in   [PULSE_LEN-1:0] bit j sent on pulse cycle j
//   ch_enable    in   [NUM_CH-1:0] per-channel enable
//   rep_count    in   [REP_W-1:0] repetitions per firing (0 acts as 1)
//   gap_len      in   [GAP_W-1:0] idle cycles between repetitions
//   start        in   fire the stored configuration (IDLE/DONE only)
//   abort        in   synchronous abort of a firing (RUN/GAP only)
//   pulse_out    out  [NUM_CH-1:0] registered transducer drive
//   busy         out  high in RUN or GAP
//   done         out  high in DONE
//   cfg_err      out  one-cycle flag on a start rejected for no enabled channel
// -----------------------------------------------------------------------------
module multi_channel_transmit_counter
    import transmit_counter_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int PULSE_LEN = 32,
    parameter int COUNT_W   = 16,
    parameter int REP_W     = 8,
    parameter int GAP_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [NUM_CH*COUNT_W-1:0] delay_in,
    input  logic [PULSE_LEN-1:0]      pulse_shape,
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic [REP_W-1:0]          rep_count,
    input  logic [GAP_W-1:0]          gap_len,
    input  logic                      start,
    input  logic                      abort,
    output logic [NUM_CH-1:0]         pulse_out,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err
);

    localparam int CW1 = COUNT_W + 1;
    localparam logic [COUNT_W:0] LEN_EXT = CW1'(PULSE_LEN);

    if (!params_valid(PULSE_LEN, COUNT_W)) begin : g_param_check
        $error("PULSE_LEN must not exceed 2**COUNT_W");
    end

    tx_state_e                 state;
    logic [COUNT_W:0]          t;
    logic [GAP_W-1:0]          g;
    logic [REP_W-1:0]          reps_left;

    logic [NUM_CH*COUNT_W-1:0] delay_q;
    logic [PULSE_LEN-1:0]      pulse_shape_q;
    logic [NUM_CH-1:0]         ch_enable_q;
    logic [REP_W-1:0]          rep_count_q;
    logic [GAP_W-1:0]          gap_len_q;
    logic [COUNT_W:0]          t_end_q;

    logic [COUNT_W:0]          t_end_next;
    logic [COUNT_W:0]          cand;
    logic                      run_active;

    // T_end = max over enabled channels of (delay + PULSE_LEN), taken from the
    // incoming configuration so it is ready in the register when loaded.
    always_comb begin
        t_end_next = '0;
        cand       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, delay_in[i*COUNT_W +: COUNT_W]} + LEN_EXT;
            if (ch_enable[i] && (cand > t_end_next)) t_end_next = cand;
        end
    end

    // Abort forces the channels low on the same edge that leaves RUN.
    assign run_active = (state == ST_RUN) && !abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            t             <= '0;
            g             <= '0;
            reps_left     <= '0;
            cfg_err       <= 1'b0;
            // NOTE: shadow config is reset too, so a start after reset sees no
            // enabled channel and is rejected instead of firing stale values.
            delay_q       <= '0;
            pulse_shape_q <= '0;
            ch_enable_q   <= '0;
            rep_count_q   <= '0;
            gap_len_q     <= '0;
            t_end_q       <= '0;
        end else begin
            cfg_err <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (load) begin
                        delay_q       <= delay_in;
                        pulse_shape_q <= pulse_shape;
                        ch_enable_q   <= ch_enable;
                        rep_count_q   <= rep_count;
                        gap_len_q     <= gap_len;
                        t_end_q       <= t_end_next;
                        state         <= ST_IDLE;
                    end else if (start) begin
                        if (ch_enable_q == '0) begin
                            cfg_err <= 1'b1;
                        end else begin
                            t         <= '0;
                            reps_left <= (rep_count_q == '0) ? REP_W'(1) : rep_count_q;
                            state     <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (t == t_end_q - CW1'(1)) begin
                        reps_left <= reps_left - REP_W'(1);
                        if (reps_left == REP_W'(1)) begin
                            state <= ST_DONE;
                        end else if (gap_len_q == '0) begin
                            t <= '0;
                        end else begin
                            g     <= gap_len_q - GAP_W'(1);
                            state <= ST_GAP;
                        end
                    end else begin
                        t <= t + CW1'(1);
                    end
                end

                ST_GAP: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (g == '0) begin
                        t     <= '0;
                        state <= ST_RUN;
                    end else begin
                        g <= g - GAP_W'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN) || (state == ST_GAP);
    assign done = (state == ST_DONE);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tx_channel #(
            .COUNT_W   (COUNT_W),
            .PULSE_LEN (PULSE_LEN)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .t      (t),
            .delay  (delay_q[i*COUNT_W +: COUNT_W]),
            .enable (ch_enable_q[i] & run_active),
            .shape  (pulse_shape_q),
            .pulse  (pulse_out[i])
        );
    end

endmodule

// File: tb/tb_multi_channel_transmit_counter.sv
// -----------------------------------------------------------------------------
// tb_multi_channel_transmit_counter
//   Scoreboard bench. The driver applies inputs on the falling edge and asks a
//   firing-level reference model what the outputs must be after the next
//   rising edge; that expectation is queued. A monitor samples the outputs
//   shortly after every rising edge and compares against the queue head.
// -----------------------------------------------------------------------------
module tb_multi_channel_transmit_counter;

    localparam int NUM_CH    = 4;
    localparam int PULSE_LEN = 32;
    localparam int COUNT_W   = 16;
    localparam int REP_W     = 8;
    localparam int GAP_W     = 16;

    typedef struct packed {
        logic              cfg_err;
        logic              done;
        logic              busy;
        logic [NUM_CH-1:0] pulse;
    } obs_t;

    logic                      clk;
    logic                      rst;
    logic                      load;
    logic [NUM_CH*COUNT_W-1:0] delay_in;
    logic [PULSE_LEN-1:0]      pulse_shape;
    logic [NUM_CH-1:0]         ch_enable;
    logic [REP_W-1:0]          rep_count;
    logic [GAP_W-1:0]          gap_len;
    logic                      start;
    logic                      abort;
    logic [NUM_CH-1:0]         pulse_out;
    logic                      busy;
    logic                      done;
    logic                      cfg_err;

    int n_checks = 0;
    int n_errors = 0;

    obs_t exp_q[$];

    // Reference model: stored configuration plus the remaining per-cycle
    // observation plan of the firing in progress (empty when not firing).
    int                   m_delay [NUM_CH];
    logic [PULSE_LEN-1:0] m_shape;
    logic [NUM_CH-1:0]    m_en;
    int                   m_rep;
    int                   m_gap;
    bit                   m_done;
    obs_t                 plan[$];

    multi_channel_transmit_counter #(
        .NUM_CH    (NUM_CH),
        .PULSE_LEN (PULSE_LEN),
        .COUNT_W   (COUNT_W),
        .REP_W     (REP_W),
        .GAP_W     (GAP_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .delay_in    (delay_in),
        .pulse_shape (pulse_shape),
        .ch_enable   (ch_enable),
        .rep_count   (rep_count),
        .gap_len     (gap_len),
        .start       (start),
        .abort       (abort),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    function automatic obs_t dut_obs();
        obs_t o;
        o.cfg_err = cfg_err;
        o.done    = done;
        o.busy    = busy;
        o.pulse   = pulse_out;
        return o;
    endfunction

    function automatic void model_reset();
        foreach (m_delay[i]) m_delay[i] = 0;
        m_shape = '0;
        m_en    = '0;
        m_rep   = 0;
        m_gap   = 0;
        m_done  = 1'b0;
        plan.delete();
    endfunction

    // Whole firing as a list of observations: the start edge, then per
    // repetition T_end pulse cycles followed by the gap (except after the last).
    function automatic void build_plan();
        int   t_end;
        int   reps;
        bit   last;
        obs_t o;
        t_end = 0;
        for (int i = 0; i < NUM_CH; i++)
            if (m_en[i] && (m_delay[i] + PULSE_LEN > t_end)) t_end = m_delay[i] + PULSE_LEN;
        reps = (m_rep == 0) ? 1 : m_rep;
        plan.push_back('{cfg_err: 1'b0, done: 1'b0, busy: 1'b1, pulse: '0});
        for (int r = 0; r < reps; r++) begin
            for (int t = 0; t < t_end; t++) begin
                last = (r == reps - 1) && (t == t_end - 1);
                o = '0;
                o.done = last;
                o.busy = !last;
                for (int i = 0; i < NUM_CH; i++)
                    if (m_en[i] && t >= m_delay[i] && t < m_delay[i] + PULSE_LEN)
                        o.pulse[i] = m_shape[t - m_delay[i]];
                plan.push_back(o);
            end
            if (r < reps - 1)
                for (int k = 0; k < m_gap; k++)
                    plan.push_back('{cfg_err: 1'b0, done: 1'b0, busy: 1'b1, pulse: '0});
        end
    endfunction

    function automatic obs_t model_step(input bit ld, input bit st, input bit ab);
        obs_t o;
        o = '0;
        if (plan.size() > 0) begin
            if (ab) begin
                plan.delete();
                m_done = 1'b0;
            end else begin
                o = plan.pop_front();
                if (plan.size() == 0) m_done = 1'b1;
            end
        end else if (ld) begin
            for (int i = 0; i < NUM_CH; i++) m_delay[i] = int'(delay_in[i*COUNT_W +: COUNT_W]);
            m_shape = pulse_shape;
            m_en    = ch_enable;
            m_rep   = int'(rep_count);
            m_gap   = int'(gap_len);
            m_done  = 1'b0;
        end else if (st) begin
            if (m_en == '0) begin
                o.cfg_err = 1'b1;
                o.done    = m_done;
            end else begin
                build_plan();
                o = plan.pop_front();
            end
        end else begin
            o.done = m_done;
        end
        return o;
    endfunction

    // One clock cycle of stimulus with its expected post-edge outputs.
    task automatic cycle(input bit ld, input bit st, input bit ab);
        @(negedge clk);
        load  = ld;
        start = st;
        abort = ab;
        exp_q.push_back(model_step(ld, st, ab));
    endtask

    task automatic reset_now();
        @(negedge clk);
        rst   = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        #1;
        check("async_reset_outputs", 64'(dut_obs()), 64'd0);
        model_reset();
        exp_q.push_back('0);
    endtask

    task automatic set_cfg(input int d0, input int d1, input int d2, input int d3,
                           input logic [31:0] sh, input logic [3:0] en,
                           input int rep, input int gap);
        delay_in    = {COUNT_W'(d3), COUNT_W'(d2), COUNT_W'(d1), COUNT_W'(d0)};
        pulse_shape = sh;
        ch_enable   = en;
        rep_count   = REP_W'(rep);
        gap_len     = GAP_W'(gap);
    endtask

    task automatic finish_firing();
        while (plan.size() > 0) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: one comparison per queued expectation, sampled after the edge.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle_outputs", 64'(dut_obs()), 64'(e));
            end
        end
    end

    initial begin
        rst   = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(0, 0, 0, 0, 32'h0, 4'h0, 0, 0);
        model_reset();

        reset_now();
        cycle(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);

        // Staggered delays, all channels, single repetition.
        set_cfg(0, 3, 5, 10, 32'hA5A5A5A5, 4'b1111, 1, 0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        finish_firing();

        // Channels 1 and 3 disabled; T_end from channels 0 and 2 only.
        set_cfg(2, 30, 7, 40, 32'h1234F00D, 4'b0101, 1, 0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        finish_firing();

        // Burst of three with a 4-cycle gap, then rep 0, then back-to-back.
        set_cfg(1, 0, 4, 2, 32'hDEADBEEF, 4'b1111, 3, 4);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        finish_firing();
        set_cfg(1, 0, 4, 2, 32'h80000001, 4'b1011, 0, 3);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        finish_firing();
        set_cfg(0, 1, 2, 3, 32'hF0F0_0F0F, 4'b1111, 2, 0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        finish_firing();

        // Abort seven cycles into RUN, then replay from t = 0.
        set_cfg(0, 3, 5, 10, 32'hA5A5A5A5, 4'b1111, 2, 2);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (7) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        finish_firing();

        // No enabled channel: rejected start. Then load+start together.
        set_cfg(0, 0, 0, 0, 32'hFFFFFFFF, 4'b0000, 1, 0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        set_cfg(4, 0, 2, 6, 32'h0000FFFF, 4'b1111, 1, 0);
        cycle(1'b1, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        finish_firing();

        // Reset in the middle of a gap, then a start on the cleared config.
        set_cfg(0, 1, 2, 3, 32'hCAFEF00D, 4'b1111, 2, 20);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (35 + 8) cycle(1'b0, 1'b0, 1'b0);
        reset_now();
        cycle(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        // Randomised firings with spurious load/start and rare aborts.
        for (int k = 0; k < 25; k++) begin
            set_cfg($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40),
                    $urandom_range(0, 40), $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), $urandom_range(0, 5));
            cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b1, 1'b0);
            while (plan.size() > 0)
                cycle($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 99) == 0);
            cycle(1'b0, 1'b0, 1'b0);
        end

        cycle(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
